// File: rtl/layer9_train_ctrl_pkg.sv
// Shared types and constants for the 9-class layer training controller.
package layer9_train_ctrl_pkg;

  localparam int unsigned NCLASS = 9;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NCLASS - 1);

  // Fraction bits alone, and the 0..1 value with one integer bit so 1.0 is exact
  typedef logic [FRAC_W-1:0] frac_t;
  typedef logic [FRAC_W:0]   zero2one_t;

  localparam zero2one_t Z2O_ZERO = '0;
  localparam zero2one_t Z2O_ONE  = {1'b1, frac_t'(0)};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SCAN,
    ST_LEARN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/argmax_serial9.sv
// Serial argmax over NCLASS values, one per enabled cycle; ties keep the lowest index.
module argmax_serial9
  import layer9_train_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             rst_n,
  input  logic             en,
  input  zero2one_t        data,
  output logic [IDX_W-1:0] idx,
  output logic             last_c,
  output logic [IDX_W-1:0] result_c
);

  zero2one_t        max_q;
  logic [IDX_W-1:0] best_q;
  logic             take_c;

  // Index 0 always loads; afterwards only a strictly larger value replaces the max
  assign take_c   = (idx == '0) || (data > max_q);
  assign last_c   = (idx == IDX_MAX);
  // Includes the value being compared this cycle so the final winner is usable on the last edge
  assign result_c = (en && take_c) ? idx : best_q;

  // Index counter and running max / winner registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      max_q  <= Z2O_ZERO;
      best_q <= '0;
    end else if (en) begin
      if (take_c) begin
        max_q  <= data;
        best_q <= idx;
      end
      idx <= last_c ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/layer9_train_ctrl.sv
// Sequences a 9-neuron layer: settle, serial argmax, optional learn pulse, result pulse.
// Optional misclassification counter enabled by defining LAYER9_TRAIN_ERR_CNT_EN.
module layer9_train_ctrl
  import layer9_train_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERRW   = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [IDX_W-1:0] label,
  input  logic             train,
  output logic             ready,
  output logic             layer_valid,
  output logic             layer_learn,
  input  zero2one_t        layer_out [NCLASS],
  output zero2one_t        expected_out [NCLASS],
  output logic [IDX_W-1:0] pred,
  output logic             pred_valid,
  output logic             correct
`ifdef LAYER9_TRAIN_ERR_CNT_EN
  ,
  output logic [ERRW-1:0]  err_count
`endif
);

  if (SETTLE < 1 || SETTLE > 15 || ERRW < 1) begin : g_param_check
    $error("layer9_train_ctrl: SETTLE must be 1..15 and ERRW at least 1");
  end

  logic [1:0]       rst_sync;
  logic             rst_int_n;
  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic [IDX_W-1:0] label_q;
  logic             train_q;
  logic [IDX_W-1:0] scan_idx;
  logic             scan_last_c;
  logic [IDX_W-1:0] result_c;
  logic             scan_en_c;
  logic             label_ok_c;
  logic             hit_c;
  zero2one_t        scan_data_c;

  // Assert asynchronously, release two edges after reset_n rises
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n   = rst_sync[1];
  assign scan_en_c   = (state == ST_SCAN);
  assign scan_data_c = layer_out[scan_idx];
  assign label_ok_c  = (label_q <= IDX_MAX);
  assign hit_c       = label_ok_c && (result_c == label_q);

  argmax_serial9 u_argmax (
    .clock    (clock),
    .rst_n    (rst_int_n),
    .en       (scan_en_c),
    .data     (scan_data_c),
    .idx      (scan_idx),
    .last_c   (scan_last_c),
    .result_c (result_c)
  );

  // Transaction FSM with all outputs registered
  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state       <= ST_IDLE;
      ready       <= 1'b1;
      layer_valid <= 1'b0;
      layer_learn <= 1'b0;
      pred_valid  <= 1'b0;
      correct     <= 1'b0;
      pred        <= '0;
      settle_cnt  <= '0;
      label_q     <= '0;
      train_q     <= 1'b0;
      for (int i = 0; i < NCLASS; i++) expected_out[i] <= Z2O_ZERO;
    end else begin
      layer_learn <= 1'b0;
      pred_valid  <= 1'b0;
      correct     <= 1'b0;
      for (int i = 0; i < NCLASS; i++) expected_out[i] <= Z2O_ZERO;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_SETTLE;
            ready       <= 1'b0;
            layer_valid <= 1'b1;
            label_q     <= label;
            train_q     <= train;
            settle_cnt  <= CNT_W'(SETTLE - 1);
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= ST_SCAN;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_SCAN: begin
          if (scan_last_c) begin
            layer_valid <= 1'b0;
            if (train_q && label_ok_c) begin
              state       <= ST_LEARN;
              layer_learn <= 1'b1;
              for (int i = 0; i < NCLASS; i++) begin
                if (IDX_W'(i) == label_q) expected_out[i] <= Z2O_ONE;
              end
            end else begin
              state      <= ST_DONE;
              pred_valid <= 1'b1;
              pred       <= result_c;
              correct    <= hit_c;
            end
          end
        end
        ST_LEARN: begin
          state      <= ST_DONE;
          pred_valid <= 1'b1;
          pred       <= result_c;
          correct    <= hit_c;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef LAYER9_TRAIN_ERR_CNT_EN
  // Saturating count of results reported with correct low
  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      err_count <= '0;
    end else if (state == ST_DONE && !correct && err_count != '1) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_layer9_train_ctrl.sv
// Directed self-checking bench for layer9_train_ctrl (SETTLE=2, ERRW=4).
module tb_layer9_train_ctrl;
  import layer9_train_ctrl_pkg::*;

  logic             clock;
  logic             reset_n;
  logic             start;
  logic [IDX_W-1:0] label;
  logic             train;
  logic             ready;
  logic             layer_valid;
  logic             layer_learn;
  zero2one_t        layer_out [NCLASS];
  zero2one_t        expected_out [NCLASS];
  logic [IDX_W-1:0] pred;
  logic             pred_valid;
  logic             correct;
`ifdef LAYER9_TRAIN_ERR_CNT_EN
  logic [3:0]       err_count;
`endif

  int n_checks;
  int n_fail;
  int err_exp;

  layer9_train_ctrl #(.SETTLE(2), .ERRW(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .label        (label),
    .train        (train),
    .ready        (ready),
    .layer_valid  (layer_valid),
    .layer_learn  (layer_learn),
    .layer_out    (layer_out),
    .expected_out (expected_out),
    .pred         (pred),
    .pred_valid   (pred_valid),
    .correct      (correct)
`ifdef LAYER9_TRAIN_ERR_CNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Ramp 10*i+5 with one or two peaks of value pv (p2 >= NCLASS means no second peak)
  task automatic set_layer(input int p1, input int p2, input int pv);
    for (int i = 0; i < NCLASS; i++) begin
      layer_out[i] = (i == p1 || i == p2) ? zero2one_t'(pv) : zero2one_t'(10 * i + 5);
    end
  endtask

  task automatic check_err(input string tag);
`ifdef LAYER9_TRAIN_ERR_CNT_EN
    check_eq(tag, int'(err_count), err_exp);
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  task automatic run_txn(input string tag, input int lbl, input bit trn,
                         input int exp_pred, input bit exp_correct,
                         input bit exp_learn, input int exp_lat);
    int        lat;
    bit        learned;
    bit        seen;
    zero2one_t snap [NCLASS];
    @(negedge clock);
    start = 1'b1;
    label = IDX_W'(lbl);
    train = trn;
    check_eq({tag, "_ready_pre"}, int'(ready), 1);
    @(posedge clock); #1;
    start = 1'b0;
    check_eq({tag, "_ready_busy"}, int'(ready), 0);
    check_eq({tag, "_lvalid"}, int'(layer_valid), 1);
    lat = 0;
    learned = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < NCLASS; i++) snap[i] = Z2O_ZERO;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (layer_learn) begin
        learned = 1'b1;
        for (int i = 0; i < NCLASS; i++) snap[i] = expected_out[i];
      end
      if (pred_valid) begin
        lat = k;
        seen = 1'b1;
        break;
      end
    end
    check_eq({tag, "_seen"}, int'(seen), 1);
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_pred"}, int'(pred), exp_pred);
    check_eq({tag, "_correct"}, int'(correct), int'(exp_correct));
    check_eq({tag, "_learn"}, int'(learned), int'(exp_learn));
    if (exp_learn) begin
      for (int i = 0; i < NCLASS; i++) begin
        check_eq($sformatf("%s_exp%0d", tag, i), int'(snap[i]),
                 (i == lbl) ? int'(Z2O_ONE) : int'(Z2O_ZERO));
      end
    end
    if (!exp_correct && err_exp < 15) err_exp++;
    @(posedge clock); #1;
    check_eq({tag, "_ready_post"}, int'(ready), 1);
    check_eq({tag, "_pvalid_post"}, int'(pred_valid), 0);
    check_eq({tag, "_correct_post"}, int'(correct), 0);
    check_eq({tag, "_pred_hold"}, int'(pred), exp_pred);
    check_eq({tag, "_exp_idle"}, int'(expected_out[lbl % NCLASS]), int'(Z2O_ZERO));
    check_err({tag, "_err"});
  endtask

  initial begin
    int lat;
    int pulses;
    n_checks = 0;
    n_fail   = 0;
    err_exp  = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    label    = '0;
    train    = 1'b0;
    set_layer(0, 99, 0);
    #12;
    check_eq("rst_ready", int'(ready), 1);
    check_eq("rst_lvalid", int'(layer_valid), 0);
    check_eq("rst_learn", int'(layer_learn), 0);
    check_eq("rst_pvalid", int'(pred_valid), 0);
    check_eq("rst_correct", int'(correct), 0);
    check_eq("rst_pred", int'(pred), 0);
    check_eq("rst_exp4", int'(expected_out[4]), 0);
    check_err("rst_err");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    @(posedge clock); #1;

    // Peak at 5, train on label 5
    set_layer(5, 99, 200);
    run_txn("t1", 5, 1'b1, 5, 1'b1, 1'b1, 12);
    // Infer only, wrong label
    set_layer(7, 99, 200);
    run_txn("t2", 3, 1'b0, 7, 1'b0, 1'b0, 11);
    // Tie between 2 and 6 resolves low; training on 6 still learns
    set_layer(2, 6, 150);
    run_txn("t3", 6, 1'b1, 2, 1'b0, 1'b1, 12);
    // Out-of-range label: no learn, never correct
    set_layer(0, 99, int'(Z2O_ONE));
    run_txn("t4", 12, 1'b1, 0, 1'b0, 1'b0, 11);
    // Full-scale peak at the last index
    set_layer(8, 99, int'(Z2O_ONE));
    run_txn("t5", 8, 1'b1, 8, 1'b1, 1'b1, 12);

    // Reset in the middle of SCAN
    set_layer(1, 99, 200);
    @(negedge clock);
    start = 1'b1;
    label = 4'd1;
    train = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_ready", int'(ready), 1);
    check_eq("mid_lvalid", int'(layer_valid), 0);
    check_eq("mid_pred", int'(pred), 0);
    check_eq("mid_pvalid", int'(pred_valid), 0);
    err_exp = 0;
    check_err("mid_err");
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (k == 2) reset_n = 1'b1;
      if (pred_valid || layer_learn) pulses++;
    end
    check_eq("mid_no_pulse", pulses, 0);
    run_txn("t6", 1, 1'b1, 1, 1'b1, 1'b1, 12);

    // Back-to-back with start held high
    set_layer(4, 99, 220);
    @(negedge clock);
    start = 1'b1;
    label = 4'd4;
    train = 1'b0;
    @(posedge clock); #1;
    check_eq("b2b_busy1", int'(ready), 0);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (pred_valid) begin lat = k; break; end
    end
    check_eq("b2b_lat1", lat, 11);
    check_eq("b2b_pred1", int'(pred), 4);
    @(posedge clock); #1;
    check_eq("b2b_ready", int'(ready), 1);
    @(posedge clock); #1;
    check_eq("b2b_busy2", int'(ready), 0);
    check_eq("b2b_lvalid2", int'(layer_valid), 1);
    start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (pred_valid) begin lat = k; break; end
    end
    check_eq("b2b_lat2", lat, 11);
    check_eq("b2b_correct2", int'(correct), 1);
    @(posedge clock); #1;

`ifdef LAYER9_TRAIN_ERR_CNT_EN
    // Drive the 4-bit counter to saturation and past it
    set_layer(3, 99, 200);
    for (int n = 0; n < 17; n++) begin
      run_txn($sformatf("sat%0d", n), 12, 1'b0, 3, 1'b0, 1'b0, 11);
    end
    check_eq("sat_final", int'(err_count), 15);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer9_train_ctrl.md
LAYER9_TRAIN_CTRL -- requirements
Module: layer9_train_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 2: cycles the 9-neuron layer is held valid before its outputs are sampled; legal range 1..15.
REQ-002 SHALL have parameter ERRW, default 16: width of the error counter.
REQ-003 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port start  in  1  sample request; accepted only on a rising edge where start && ready.
REQ-006 SHALL have port label  in  4  target class 0..8, captured at accept.
REQ-007 SHALL have port train  in  1  1 = infer then learn; 0 = infer only; captured at accept.
REQ-008 SHALL have port ready  out  1  high only in IDLE.
REQ-009 SHALL have port layer_valid  out  1  drives the downstream 9-neuron learn layer's valid.
REQ-010 SHALL have port layer_learn  out  1  drives that layer's learn.
REQ-011 SHALL have port layer_out  in  zero2one_t[9]  layer outputs.
REQ-012 SHALL have port expected_out  out  zero2one_t[9]  training target to the layer.
REQ-013 SHALL have port pred  out  4  argmax class index.
REQ-014 SHALL have port pred_valid  out  1  one-cycle pulse; pred and correct are valid with it.
REQ-015 SHALL have port correct  out  1  pred == captured label.
REQ-016 SHALL have port err_count  out  ERRW  misclassification count; present only with the REQ-031 macro.

Function
REQ-017 SHALL implement FSM states IDLE, SETTLE, SCAN, LEARN, DONE.
REQ-018 IDLE -> SETTLE on accept; label and train SHALL be registered on the accepting edge; start while not ready SHALL be ignored.
REQ-019 SETTLE SHALL last exactly SETTLE cycles, counted by a down-counter; layer_valid = 1 in SETTLE and SCAN only.
REQ-020 SCAN SHALL last exactly 9 cycles, index i = 0..8, comparing layer_out[i] to the running max.
- Running max is loaded at i = 0.
- Update uses strict greater-than, so ties resolve to the lowest index.
REQ-021 After SCAN, state SHALL go to LEARN if captured train = 1 and label <= 8; otherwise it SHALL go to DONE.
REQ-022 LEARN SHALL last 1 cycle with layer_learn = 1.
- expected_out[label] = Z2O_ONE; all other entries = Z2O_ZERO.
- Outside LEARN, all expected_out entries SHALL be Z2O_ZERO.
REQ-023 DONE SHALL last 1 cycle with pred_valid = 1; correct = (label <= 8 && pred == label); DONE -> IDLE.
REQ-024 Latency: pred_valid SHALL be high in the cycle beginning SETTLE+9+L rising edges after the accepting edge, L = 1 if LEARN was visited, else 0.
REQ-025 pred SHALL hold its last value until the next DONE; correct SHALL be 0 outside DONE.
REQ-026 label > 8 SHALL suppress learning and force correct = 0; pred is still reported.
REQ-027 start held high SHALL yield back-to-back transactions, with ready re-asserting the cycle after DONE.

Reset
REQ-028 While reset_n = 0, the block SHALL asynchronously force the following.
- State = IDLE; ready = 1.
- layer_valid = layer_learn = pred_valid = correct = 0.
- pred = 0; expected_out = all Z2O_ZERO; err_count = 0.
- All counters and the running max = 0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no pred_valid and no layer_learn pulse afterwards.
REQ-030 Reset deassertion SHALL be synchronised internally, releasing 2 edges later; accept is possible from the 3rd edge.

Configuration
REQ-031 With LAYER9_TRAIN_ERR_CNT_EN defined, err_count SHALL exist and increment in DONE when correct = 0, saturating at 2^ERRW-1.
- Without the macro, the port and its logic SHALL be absent.

Structure
REQ-032 Z2O_ZERO, Z2O_ONE, the FSM state enum and NCLASS = 9 SHALL live in the shared package alongside zero2one_t and frac_t (defs.svh).
REQ-033 The serial argmax (index counter, max register, tie rule) SHALL be a sub-module, argmax_serial9.

Verification
REQ-034 The bench SHALL cover the following directed scenarios.
- SETTLE=2; layer_out peak at index 5; label=5, train=1 -> layer_learn pulse; expected_out[5]=ONE, others ZERO; pred_valid 12 cycles after accept; pred=5, correct=1.
- train=0, label=3, peak at index 7 -> no layer_learn; pred_valid after 11 cycles; pred=7, correct=0; err_count 0->1 with the macro.
- Equal max at indices 2 and 6 -> pred=2.
- label=12, train=1 -> no learn; correct=0; pred still reported.
- reset_n low during SCAN -> outputs at reset values immediately; no pred_valid follows; the next transaction completes normally.
- err_count preset to 2^ERRW-1 (ERRW=4, value 15), then a miss -> stays 15.
